// File: rtl/demux32_route.sv
// ----------------------------------------------------------------------------
// demux32_route
//   Registered 1-to-2 demultiplexer for WIDTH-bit words with valid/ready
//   handshakes. One producer stream is steered to port 1 (select_i=0) or
//   port 2 (select_i=1). Each port owns a one-entry holding slot, so a stalled
//   consumer only blocks words addressed to it. Saturating per-port delivery
//   counters are provided for debug/perf.
//
//   Per-port slot state (carried by validN_q):
//     state | meaning
//     EMPTY | validN_o=0, dataN_o holds last delivered word (ignore it)
//     FULL  | validN_o=1, dataN_o held stable until drained
//
// Ports
//   clk_i     clock, rising edge
//   rst_i     synchronous reset, active-high
//   data_i    input word
//   select_i  destination (0 -> port 1, 1 -> port 2), sampled with valid_i
//   valid_i   input word valid
//   ready_o   block can accept input this cycle (combinational)
//   data1_o   port 1 word          data2_o   port 2 word
//   valid1_o  port 1 slot full     valid2_o  port 2 slot full
//   ready1_i  port 1 accepts       ready2_i  port 2 accepts
//   count1_o  words delivered on port 1 (saturating)
//   count2_o  words delivered on port 2 (saturating)
// ----------------------------------------------------------------------------
module demux32_route #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             select_i,
    input  logic             valid_i,
    output logic             ready_o,
    output logic [WIDTH-1:0] data1_o,
    output logic             valid1_o,
    input  logic             ready1_i,
    output logic [WIDTH-1:0] data2_o,
    output logic             valid2_o,
    input  logic             ready2_i,
    output logic [CNT_W-1:0] count1_o,
    output logic [CNT_W-1:0] count2_o
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [WIDTH-1:0] data1_q, data1_d;
    logic [WIDTH-1:0] data2_q, data2_d;
    logic             valid1_q, valid1_d;
    logic             valid2_q, valid2_d;
    logic [CNT_W-1:0] count1_q, count1_d;
    logic [CNT_W-1:0] count2_q, count2_d;

    logic accept;
    logic load1, load2;
    logic drain1, drain2;

    // A full slot can still take a word if it drains in the same cycle,
    // which is what gives 1 word/cycle throughput with no bubble.
    assign ready_o = select_i ? (~valid2_q | ready2_i) : (~valid1_q | ready1_i);

    assign accept = valid_i & ready_o;
    assign load1  = accept & ~select_i;
    assign load2  = accept &  select_i;
    assign drain1 = valid1_q & ready1_i;
    assign drain2 = valid2_q & ready2_i;

    always_comb begin
        valid1_d = load1 | (valid1_q & ~drain1);
        valid2_d = load2 | (valid2_q & ~drain2);
        data1_d  = load1 ? data_i : data1_q;
        data2_d  = load2 ? data_i : data2_q;

        count1_d = count1_q;
        if (drain1 && (count1_q != CNT_MAX)) begin
            count1_d = count1_q + CNT_ONE;
        end

        count2_d = count2_q;
        if (drain2 && (count2_q != CNT_MAX)) begin
            count2_d = count2_q + CNT_ONE;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            data1_q  <= '0;
            data2_q  <= '0;
            valid1_q <= 1'b0;
            valid2_q <= 1'b0;
            count1_q <= '0;
            count2_q <= '0;
        end else begin
            data1_q  <= data1_d;
            data2_q  <= data2_d;
            valid1_q <= valid1_d;
            valid2_q <= valid2_d;
            count1_q <= count1_d;
            count2_q <= count2_d;
        end
    end

    assign data1_o  = data1_q;
    assign data2_o  = data2_q;
    assign valid1_o = valid1_q;
    assign valid2_o = valid2_q;
    assign count1_o = count1_q;
    assign count2_o = count2_q;

endmodule

// File: tb/tb_demux32_route.sv
// ----------------------------------------------------------------------------
// tb_demux32_route
//   Directed-vector bench for demux32_route. A second instance with CNT_W=2
//   shares the stimulus and is only inspected for counter saturation.
// ----------------------------------------------------------------------------
module tb_demux32_route;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic [31:0] data_i;
    logic        select_i;
    logic        valid_i;
    logic        ready1_i;
    logic        ready2_i;

    logic        ready_o;
    logic [31:0] data1_o, data2_o;
    logic        valid1_o, valid2_o;
    logic [7:0]  count1_o, count2_o;

    logic        s_ready_o;
    logic [31:0] s_data1_o, s_data2_o;
    logic        s_valid1_o, s_valid2_o;
    logic [1:0]  s_count1_o, s_count2_o;

    int checks   = 0;
    int failures = 0;

    always #5 clk_i = ~clk_i;

    demux32_route #(.WIDTH(32), .CNT_W(8)) dut (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .data_i   (data_i),
        .select_i (select_i),
        .valid_i  (valid_i),
        .ready_o  (ready_o),
        .data1_o  (data1_o),
        .valid1_o (valid1_o),
        .ready1_i (ready1_i),
        .data2_o  (data2_o),
        .valid2_o (valid2_o),
        .ready2_i (ready2_i),
        .count1_o (count1_o),
        .count2_o (count2_o)
    );

    demux32_route #(.WIDTH(32), .CNT_W(2)) dut_sat (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .data_i   (data_i),
        .select_i (select_i),
        .valid_i  (valid_i),
        .ready_o  (s_ready_o),
        .data1_o  (s_data1_o),
        .valid1_o (s_valid1_o),
        .ready1_i (ready1_i),
        .data2_o  (s_data2_o),
        .valid2_o (s_valid2_o),
        .ready2_i (ready2_i),
        .count1_o (s_count1_o),
        .count2_o (s_count2_o)
    );

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic do_reset();
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
    endtask

    initial begin
        rst_i    = 1'b0;
        data_i   = '0;
        select_i = 1'b0;
        valid_i  = 1'b0;
        ready1_i = 1'b0;
        ready2_i = 1'b0;
        tick();
        do_reset();

        // reset state
        check_val("rst_valid1", 32'(valid1_o), 32'd0);
        check_val("rst_valid2", 32'(valid2_o), 32'd0);
        check_val("rst_data1", data1_o, 32'h0);
        check_val("rst_data2", data2_o, 32'h0);
        check_val("rst_count1", 32'(count1_o), 32'd0);
        check_val("rst_count2", 32'(count2_o), 32'd0);
        check_val("rst_ready", 32'(ready_o), 32'd1);

        // 1: single word to port 1
        valid_i = 1'b1; select_i = 1'b0; data_i = 32'hDEADBEEF; ready1_i = 1'b1;
        tick();
        valid_i = 1'b0;
        check_val("t1_valid1", 32'(valid1_o), 32'd1);
        check_val("t1_data1", data1_o, 32'hDEADBEEF);
        check_val("t1_valid2", 32'(valid2_o), 32'd0);
        check_val("t1_count1_pre", 32'(count1_o), 32'd0);
        tick();
        check_val("t1_count1", 32'(count1_o), 32'd1);
        check_val("t1_valid1_drained", 32'(valid1_o), 32'd0);

        // 2: stall on port 2
        ready2_i = 1'b0;
        valid_i = 1'b1; select_i = 1'b1; data_i = 32'h11;
        #1;
        check_val("t2_ready_first", 32'(ready_o), 32'd1);
        tick();
        data_i = 32'h22;
        #1;
        check_val("t2_data2_a", data2_o, 32'h11);
        check_val("t2_ready_stalled", 32'(ready_o), 32'd0);
        tick();
        check_val("t2_data2_held", data2_o, 32'h11);
        check_val("t2_valid2_held", 32'(valid2_o), 32'd1);
        ready2_i = 1'b1;
        #1;
        check_val("t2_ready_release", 32'(ready_o), 32'd1);
        tick();
        valid_i = 1'b0;
        check_val("t2_data2_b", data2_o, 32'h22);
        check_val("t2_valid2_b", 32'(valid2_o), 32'd1);
        check_val("t2_count2_mid", 32'(count2_o), 32'd1);
        tick();
        check_val("t2_count2", 32'(count2_o), 32'd2);
        check_val("t2_valid2_drained", 32'(valid2_o), 32'd0);

        // 3: port 2 full and stalled, port 1 streams 1,2,3
        ready2_i = 1'b0;
        valid_i = 1'b1; select_i = 1'b1; data_i = 32'h33;
        tick();
        ready1_i = 1'b1; select_i = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            data_i = 32'(i);
            #1;
            check_val("t3_ready", 32'(ready_o), 32'd1);
            tick();
            check_val("t3_data1", data1_o, 32'(i));
            check_val("t3_valid1", 32'(valid1_o), 32'd1);
            check_val("t3_data2", data2_o, 32'h33);
            check_val("t3_valid2", 32'(valid2_o), 32'd1);
        end
        valid_i = 1'b0;
        tick();
        check_val("t3_count1", 32'(count1_o), 32'd4);
        check_val("t3_count2", 32'(count2_o), 32'd2);

        // 4: simultaneous drain and load on port 1
        ready1_i = 1'b0;
        valid_i = 1'b1; select_i = 1'b0; data_i = 32'hA;
        tick();
        valid_i = 1'b0;
        check_val("t4_data1_a", data1_o, 32'hA);
        ready1_i = 1'b1;
        valid_i = 1'b1; data_i = 32'hB;
        #1;
        check_val("t4_ready", 32'(ready_o), 32'd1);
        tick();
        valid_i = 1'b0;
        check_val("t4_data1_b", data1_o, 32'hB);
        check_val("t4_valid1", 32'(valid1_o), 32'd1);
        check_val("t4_count1", 32'(count1_o), 32'd5);
        tick();
        check_val("t4_count1_after", 32'(count1_o), 32'd6);

        // 5: saturation on the CNT_W=2 instance
        do_reset();
        ready1_i = 1'b1; ready2_i = 1'b0; select_i = 1'b0;
        for (int i = 0; i <= 5; i++) begin
            valid_i = (i < 5);
            data_i  = 32'(i + 1);
            tick();
            if (i >= 1) begin
                check_val("t5_sat_count1", 32'(s_count1_o), (i < 3) ? 32'(i) : 32'd3);
                check_val("t5_count1", 32'(count1_o), 32'(i));
            end
        end
        check_val("t5_sat_count2", 32'(s_count2_o), 32'd0);

        // 6: reset with both slots full and stalled
        ready1_i = 1'b0; ready2_i = 1'b0;
        valid_i = 1'b1; select_i = 1'b0; data_i = 32'h55;
        tick();
        select_i = 1'b1; data_i = 32'h66;
        tick();
        valid_i = 1'b0; select_i = 1'b0;
        #1;
        check_val("t6_ready_full1", 32'(ready_o), 32'd0);
        select_i = 1'b1;
        #1;
        check_val("t6_ready_full2", 32'(ready_o), 32'd0);
        check_val("t6_valid1", 32'(valid1_o), 32'd1);
        check_val("t6_data2", data2_o, 32'h66);
        check_val("t6_count1_pre", 32'(count1_o), 32'd5);
        do_reset();
        check_val("t6_valid1_rst", 32'(valid1_o), 32'd0);
        check_val("t6_valid2_rst", 32'(valid2_o), 32'd0);
        check_val("t6_data1_rst", data1_o, 32'h0);
        check_val("t6_data2_rst", data2_o, 32'h0);
        check_val("t6_count1_rst", 32'(count1_o), 32'd0);
        check_val("t6_count2_rst", 32'(count2_o), 32'd0);
        check_val("t6_ready_rst", 32'(ready_o), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
